// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-controller state encoding, default clocking
// constants and the cycles-per-bit helper used by the rx/tx blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ARM    = 2'd1,
        ST_FRAME  = 2'd2,
        ST_COMMIT = 2'd3
    } ctrl_state_e;

    localparam int unsigned CLK_HZ_DEFAULT = 32'd50_000_000;
    localparam int unsigned BAUD_DEFAULT   = 32'd115_200;

    // Rounded division so the bit period error stays within half a clock.
    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned baud);
        if (baud == 32'd0) begin
            return 32'd0;
        end else begin
            return (clk_hz + (baud >> 1)) / baud;
        end
    endfunction

    localparam int unsigned CYCLES_PER_BIT_DEFAULT = cycles_per_bit(CLK_HZ_DEFAULT, BAUD_DEFAULT);

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus-side pop interface of the receive FIFO; the controller drives head data,
// valid and occupancy, the consumer drives ready.
interface uart_rx_ctrl_if #(
    parameter int P_FIFO_DEPTH = 8
);
    localparam int LW = $clog2(P_FIFO_DEPTH) + 1;

    logic [7:0]    fifo_data_o;
    logic          fifo_valid_o;
    logic          fifo_ready_i;
    logic [LW-1:0] fifo_level_o;

    modport master (
        output fifo_data_o,
        output fifo_valid_o,
        output fifo_level_o,
        input  fifo_ready_i
    );

    modport slave (
        input  fifo_data_o,
        input  fifo_valid_o,
        input  fifo_level_o,
        output fifo_ready_i
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop frees an entry in the same cycle.
module uart_sync_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 8,
    localparam int AW = $clog2(P_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [P_WIDTH-1:0] data_i,
    input  logic               pop_i,
    output logic [P_WIDTH-1:0] data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LW-1:0]      level_o
);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               do_push_s, do_pop_s;

    assign empty_o   = (level_q == {LW{1'b0}});
    assign full_o    = (level_q == LW'(P_DEPTH));
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign data_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Pointer and occupancy next state; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for one uart_rx: arms/disarms it, gathers per-frame
// status, commits bytes into a FIFO and keeps error, overrun and idle statistics.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int P_FIFO_DEPTH  = 8,
    parameter int P_DROP_ERR    = 1,
    parameter int P_IDLE_CYCLES = 0,
    parameter int P_CNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               parity_en_cfg_i,
    input  logic               parity_sel_cfg_i,
    input  logic               clear_stats_i,
    output logic               rx_enable_o,
    output logic               rx_parity_en_o,
    output logic               rx_parity_sel_o,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_busy_i,
    input  logic               rx_data_ready_i,
    input  logic               rx_parity_err_i,
    input  logic               rx_framing_err_i,
    uart_rx_ctrl_if.master     fifo_if,
    output logic               overrun_o,
    output logic [P_CNT_W-1:0] parity_err_cnt_o,
    output logic [P_CNT_W-1:0] framing_err_cnt_o,
    output logic               idle_timeout_o,
    output logic               armed_o
);

    localparam int LW = $clog2(P_FIFO_DEPTH) + 1;
    localparam int IW = (P_IDLE_CYCLES > 0) ? $clog2(P_IDLE_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(P_IDLE_CYCLES);
    localparam logic IDLE_EN  = (P_IDLE_CYCLES > 0);
    localparam logic DROP_ERR = (P_DROP_ERR != 0);

    function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + P_CNT_W'(1);
        end
    endfunction

    ctrl_state_e        state_q, state_d;
    logic               rx_en_q, rx_en_d;
    logic               armed_q, armed_d;
    logic               par_en_q, par_en_d;
    logic               par_sel_q, par_sel_d;
    logic               stop_pend_q, stop_pend_d;
    logic               got_q, got_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               busy_prev_q, drdy_prev_q;
    logic [P_CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [P_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic               overrun_q, overrun_d;
    logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
    logic               idle_run_q, idle_run_d;
    logic               idle_pulse_q, idle_pulse_d;

    logic               push_s, pop_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [7:0]         fifo_data_s;
    logic [LW-1:0]      fifo_level_s;

    assign pop_s = fifo_if.fifo_ready_i & ~fifo_empty_s;

    uart_sync_fifo #(
        .P_WIDTH (8),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (rx_data_i),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    // Controller next state, per-frame flags, statistics and idle timer.
    always_comb begin
        state_d      = state_q;
        par_en_d     = par_en_q;
        par_sel_d    = par_sel_q;
        stop_pend_d  = stop_pend_q;
        got_d        = got_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        par_cnt_d    = par_cnt_q;
        frm_cnt_d    = frm_cnt_q;
        overrun_d    = overrun_q;
        idle_cnt_d   = idle_cnt_q;
        idle_run_d   = idle_run_q;
        idle_pulse_d = 1'b0;
        push_s       = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (start_i) begin
                    state_d   = ST_ARM;
                    par_en_d  = parity_en_cfg_i;
                    par_sel_d = parity_sel_cfg_i;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_ARM: begin
                // A frame already under way outranks a disarm request.
                if (rx_busy_i) begin
                    state_d     = ST_FRAME;
                    got_d       = 1'b0;
                    perr_d      = 1'b0;
                    ferr_d      = 1'b0;
                    stop_pend_d = stop_pend_q | stop_i;
                end else if (stop_i) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_FRAME: begin
                if (rx_data_ready_i & ~drdy_prev_q) begin
                    got_d = 1'b1;
                end else begin
                    got_d = got_q;
                end
                perr_d      = perr_q | rx_parity_err_i;
                ferr_d      = ferr_q | rx_framing_err_i;
                stop_pend_d = stop_pend_q | stop_i;
                if (busy_prev_q & ~rx_busy_i) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            ST_COMMIT: begin
                push_s = got_q & ~(DROP_ERR & (perr_q | ferr_q));
                if (got_q & perr_q) begin
                    par_cnt_d = sat_inc(par_cnt_q);
                end else begin
                    par_cnt_d = par_cnt_q;
                end
                if (got_q & ferr_q) begin
                    frm_cnt_d = sat_inc(frm_cnt_q);
                end else begin
                    frm_cnt_d = frm_cnt_q;
                end
                if (stop_pend_q | stop_i) begin
                    state_d     = ST_OFF;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = ST_ARM;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (push_s & fifo_full_s & ~pop_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // Timer restarts on every accepted byte and freezes once it has fired.
        if (push_s) begin
            idle_cnt_d = {IW{1'b0}};
            idle_run_d = IDLE_EN;
        end else if ((state_q == ST_ARM) && idle_run_q && (idle_cnt_q != IDLE_MAX)) begin
            idle_cnt_d   = idle_cnt_q + IW'(1);
            idle_pulse_d = (idle_cnt_d == IDLE_MAX);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
        idle_run_d   = idle_run_d & (state_d != ST_OFF);
        idle_pulse_d = idle_pulse_d & (state_d != ST_OFF);

        par_cnt_d = clear_stats_i ? {P_CNT_W{1'b0}} : par_cnt_d;
        frm_cnt_d = clear_stats_i ? {P_CNT_W{1'b0}} : frm_cnt_d;
        overrun_d = clear_stats_i ? 1'b0 : overrun_d;

        rx_en_d = (state_d != ST_OFF);
        armed_d = (state_d != ST_OFF);
    end

    // Controller and statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_OFF;
            rx_en_q      <= 1'b0;
            armed_q      <= 1'b0;
            par_en_q     <= 1'b0;
            par_sel_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            got_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            busy_prev_q  <= 1'b0;
            drdy_prev_q  <= 1'b0;
            par_cnt_q    <= {P_CNT_W{1'b0}};
            frm_cnt_q    <= {P_CNT_W{1'b0}};
            overrun_q    <= 1'b0;
            idle_cnt_q   <= {IW{1'b0}};
            idle_run_q   <= 1'b0;
            idle_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_en_q      <= rx_en_d;
            armed_q      <= armed_d;
            par_en_q     <= par_en_d;
            par_sel_q    <= par_sel_d;
            stop_pend_q  <= stop_pend_d;
            got_q        <= got_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            busy_prev_q  <= rx_busy_i;
            drdy_prev_q  <= rx_data_ready_i;
            par_cnt_q    <= par_cnt_d;
            frm_cnt_q    <= frm_cnt_d;
            overrun_q    <= overrun_d;
            idle_cnt_q   <= idle_cnt_d;
            idle_run_q   <= idle_run_d;
            idle_pulse_q <= idle_pulse_d;
        end
    end

    assign rx_enable_o        = rx_en_q;
    assign armed_o            = armed_q;
    assign rx_parity_en_o     = par_en_q;
    assign rx_parity_sel_o    = par_sel_q;
    assign overrun_o          = overrun_q;
    assign parity_err_cnt_o   = par_cnt_q;
    assign framing_err_cnt_o  = frm_cnt_q;
    assign idle_timeout_o     = idle_pulse_q;
    assign fifo_if.fifo_data_o  = fifo_data_s;
    assign fifo_if.fifo_valid_o = ~fifo_empty_s;
    assign fifo_if.fifo_level_o = fifo_level_s;

endmodule
